// File: rtl/rom_loader_pkg.sv
// Shared types and widths for the ROM download front-end.
package rom_loader_pkg;

    localparam int DL_ADDR_W = 25;
    localparam int CNT_W     = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_loader.sv
// Decodes the ioctl byte stream into per-ROM load strobes and checks image integrity.
// Latency: accepted byte in cycle N drives iload/iaddr/idata in cycle N+1.
// Backpressure: none; one byte per cycle is always absorbed, dl_wr every cycle is lossless.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int          NUM_REGIONS = 8,
    parameter int          REGION_BITS = 16,
    parameter logic [31:0] TOTAL_BYTES = 32'h60000,
    parameter logic [7:0]  ROM_INDEX   = 8'd0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dl_active,
    input  logic                   dl_wr,
    input  logic [7:0]             dl_index,
    input  logic [DL_ADDR_W-1:0]   dl_addr,
    input  logic [7:0]             dl_data,
    output logic [REGION_BITS-1:0] iaddr,
    output logic [7:0]             idata,
    output logic [NUM_REGIONS-1:0] iload,
    output logic                   loading,
    output logic                   done,
    output logic                   game_reset_n,
    output logic                   err_seq,
    output logic                   err_size
);

    localparam int               RGN_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int               HI_LSB  = REGION_BITS + RGN_W;
    localparam logic [RGN_W:0]   NR_L    = NUM_REGIONS[RGN_W:0];
    localparam logic [CNT_W-1:0] TOTAL_L = TOTAL_BYTES[CNT_W-1:0];

    state_t                 state, state_nx;
    logic                   act_q;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [DL_ADDR_W-1:0]   exp_addr, exp_nx;
    logic                   seq_nx, size_nx;
    logic [NUM_REGIONS-1:0] iload_nx;

    logic                   idx_ok, rise, load_start, acc, addr_ok;
    logic [RGN_W-1:0]       region;
    logic [DL_ADDR_W-1:0]   hi_bits;

    assign idx_ok     = (dl_index == ROM_INDEX);
    assign rise       = dl_active & ~act_q;
    assign load_start = rise & idx_ok & ((state == IDLE) | (state == DONE));
    // A byte arriving in the very cycle the download starts belongs to the new image.
    assign acc        = dl_wr & dl_active & idx_ok & ((state == LOAD) | load_start);

    assign region  = dl_addr[REGION_BITS +: RGN_W];
    assign hi_bits = dl_addr >> HI_LSB;
    assign addr_ok = (hi_bits == '0) && ({1'b0, region} < NR_L);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load_start) state_nx = LOAD;
            LOAD:    if (!dl_active) state_nx = FLUSH;
            FLUSH:   state_nx = DONE;
            DONE:    if (load_start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx   = load_start ? '0   : cnt;
        exp_nx   = load_start ? '0   : exp_addr;
        seq_nx   = load_start ? 1'b0 : err_seq;
        size_nx  = load_start ? 1'b0 : err_size;
        iload_nx = '0;
        if (acc) begin
            if (dl_addr != exp_nx)
                seq_nx = 1'b1;
            exp_nx = dl_addr + 1'b1;
            if (cnt_nx != '1)
                cnt_nx = cnt_nx + 1'b1;
            if (addr_ok)
                iload_nx[region] = 1'b1;
            else
                size_nx = 1'b1;
        end
        if ((state == FLUSH) && (cnt != TOTAL_L))
            size_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // act_q resets high so a download already in flight at reset release is not picked up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q    <= 1'b1;
            cnt      <= '0;
            exp_addr <= '0;
            err_seq  <= 1'b0;
            err_size <= 1'b0;
            iload    <= '0;
            iaddr    <= '0;
            idata    <= '0;
        end else begin
            act_q    <= dl_active;
            cnt      <= cnt_nx;
            exp_addr <= exp_nx;
            err_seq  <= seq_nx;
            err_size <= size_nx;
            iload    <= iload_nx;
            if (acc && addr_ok) begin
                iaddr <= dl_addr[REGION_BITS-1:0];
                idata <= dl_data;
            end
        end
    end

    assign loading      = (state == LOAD) | (state == FLUSH);
    assign done         = (state == DONE) & ~(err_seq | err_size);
    assign game_reset_n = done;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized and directed checks of rom_loader against a byte-level image model.
module tb_rom_loader;

    localparam int          NR = 8;
    localparam int          RB = 8;
    localparam int          RSZ = 1 << RB;
    localparam logic [31:0] TB_BYTES = 32'h600;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          dl_active = 1'b0;
    logic          dl_wr = 1'b0;
    logic [7:0]    dl_index = 8'd0;
    logic [24:0]   dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic [RB-1:0] iaddr;
    logic [7:0]    idata;
    logic [NR-1:0] iload;
    logic          loading, done, game_reset_n, err_seq, err_size;

    rom_loader #(
        .NUM_REGIONS (NR),
        .REGION_BITS (RB),
        .TOTAL_BYTES (TB_BYTES),
        .ROM_INDEX   (8'd0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dl_active    (dl_active),
        .dl_wr        (dl_wr),
        .dl_index     (dl_index),
        .dl_addr      (dl_addr),
        .dl_data      (dl_data),
        .iaddr        (iaddr),
        .idata        (idata),
        .iload        (iload),
        .loading      (loading),
        .done         (done),
        .game_reset_n (game_reset_n),
        .err_seq      (err_seq),
        .err_size     (err_size)
    );

    always #5 clk = ~clk;

    // ROM contents as the game would see them, built from the load strobes.
    logic [7:0] rom_mem [0:NR*RSZ-1];
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            if (iload[i]) rom_mem[i*RSZ + int'(iaddr)] <= idata;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]    img [0:NR*RSZ-1];
    bit            armed, m_seq, m_size, m_done;
    int            m_cnt;
    longint        exp_next;
    logic [RB-1:0] last_a;
    logic [7:0]    last_d;
    logic [NR-1:0] hit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        armed  = 0;
        m_seq  = 0;
        m_size = 0;
        m_done = 0;
        m_cnt  = 0;
        exp_next = 0;
        last_a = '0;
        last_d = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_iaddr"}, iaddr, 0);
        check({tag, "_idata"}, idata, 0);
        check({tag, "_iload"}, iload, 0);
        check({tag, "_loading"}, loading, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_grst"}, game_reset_n, 0);
        check({tag, "_eseq"}, err_seq, 0);
        check({tag, "_esize"}, err_size, 0);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        dl_index  = idx;
        dl_active = 1'b1;
        tick();
        if (idx == 8'd0) begin
            armed  = 1;
            m_seq  = 0;
            m_size = 0;
            m_done = 0;
            m_cnt  = 0;
            exp_next = 0;
        end
        check("start_loading", loading, (idx == 8'd0) ? 1 : 0);
        check("start_done", done, m_done);
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        logic [NR-1:0] e_iload;
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        tick();
        dl_wr   = 1'b0;
        e_iload = '0;
        if (armed && dl_index == 8'd0) begin
            m_cnt++;
            if (longint'(a) != exp_next) m_seq = 1;
            exp_next = longint'(a) + 1;
            if (int'(a) >= NR*RSZ) begin
                m_size = 1;
            end else begin
                e_iload = '0;
                e_iload[int'(a) / RSZ] = 1'b1;
                last_a = a[RB-1:0];
                last_d = d;
                img[int'(a)] = d;
            end
        end
        hit |= iload;
        check("wr_iload", iload, e_iload);
        check("wr_iaddr", iaddr, last_a);
        check("wr_idata", idata, last_d);
        check("wr_eseq", err_seq, m_seq);
        check("wr_esize", err_size, m_size);
    endtask

    // Ends the download; a byte strobed in the falling cycle must be ignored.
    task automatic end_dl();
        bit was_armed;
        dl_active = 1'b0;
        dl_addr   = 25'(exp_next);
        dl_data   = 8'hFF;
        dl_wr     = 1'b1;
        tick();
        dl_wr     = 1'b0;
        check("end_iload", iload, 0);
        was_armed = armed;
        armed = 0;
        if (was_armed) begin
            check("flush_loading", loading, 1);
            check("flush_done", done, 0);
            if (m_cnt != int'(TB_BYTES)) m_size = 1;
            m_done = !(m_seq || m_size);
        end
        tick();
        check("end_done", done, m_done);
        check("end_grst", game_reset_n, m_done);
        check("end_eseq", err_seq, m_seq);
        check("end_esize", err_size, m_size);
        check("end_loading", loading, 0);
    endtask

    task automatic compare_image(input string tag);
        int mism = 0;
        for (int a = 0; a < int'(TB_BYTES); a++)
            if (rom_mem[a] !== img[a]) mism++;
        check(tag, mism, 0);
    endtask

    initial begin
        model_reset();
        hit = '0;

        // Reset values
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_reset_vals("post_rst");

        // Full sequential load, data = addr[7:0], back-to-back strobes
        hit = '0;
        start_dl(8'd0);
        for (int a = 0; a < int'(TB_BYTES); a++)
            write_byte(25'(a), 8'(a));
        check("regions_hit", hit, 8'h3F);
        end_dl();
        check("load1_done", done, 1);
        compare_image("load1_image");

        // Other index while DONE: nothing moves
        start_dl(8'd1);
        for (int i = 0; i < 4; i++)
            write_byte(25'($urandom_range(0, int'(TB_BYTES) - 1)), 8'($urandom));
        check("idx1_done", done, 1);
        end_dl();
        check("idx1_done_after", done, 1);
        dl_index = 8'd0;

        // Directed decode and out-of-range region
        start_dl(8'd0);
        write_byte(25'h105, 8'hA5);
        check("dir_iload", iload, 8'b0000_0010);
        check("dir_iaddr", iaddr, 8'h05);
        check("dir_idata", idata, 8'hA5);
        write_byte(25'h800, 8'h3C);
        check("r8_iload", iload, 0);
        check("r8_esize", err_size, 1);
        end_dl();
        check("dir_done", done, 0);

        // Full load with one skipped address and random idle gaps
        start_dl(8'd0);
        for (int a = 0; a < int'(TB_BYTES); a++) begin
            if (a == 'h100) continue;
            if ($urandom_range(0, 7) == 0) tick();
            write_byte(25'(a), 8'($urandom));
        end
        end_dl();
        check("skip_eseq", err_seq, 1);
        check("skip_esize", err_size, 1);
        check("skip_grst", game_reset_n, 0);

        // Reset mid-load, stale download ignored, then a clean reload
        start_dl(8'd0);
        for (int a = 0; a < 100; a++)
            write_byte(25'(a), 8'($urandom));
        reset_n = 1'b0;
        model_reset();
        #1 check_reset_vals("mid_rst");
        tick();
        reset_n = 1'b1;
        tick();
        for (int a = 100; a < 104; a++)
            write_byte(25'(a), 8'($urandom));
        check_reset_vals("stale_dl");
        dl_active = 1'b0;
        tick();
        start_dl(8'd0);
        for (int a = 0; a < int'(TB_BYTES); a++) begin
            if ($urandom_range(0, 5) == 0) tick();
            write_byte(25'(a), 8'($urandom));
        end
        end_dl();
        check("reload_done", done, 1);
        check("reload_eseq", err_seq, 0);
        check("reload_esize", err_size, 0);
        compare_image("reload_image");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
